// File: rtl/ahb_lite_slv_sif.sv
// ----------------------------------------------------------------------------
// ahb_lite_slv_sif
//
// AHB-Lite subordinate that turns each accepted AHB transfer into one
// single-beat request toward a register-file client (for example a CSR block).
// The request is issued in the first AHB data-phase cycle. Client stalls (hld)
// stretch the data phase. Client errors (err), or an access wider than the
// client data path, produce the two-cycle AHB ERROR response.
//
// Handshake semantics (client side):
//   dv is a one-cycle pulse in the first data-phase cycle of each transfer.
//   addr/write stay stable for the whole data phase. During every data-phase
//   cycle the client answers combinationally:
//     err=1          -> request failed. This cycle is ERROR cycle 1.
//     err=0, hld=1   -> not finished yet. One more wait state.
//     err=0, hld=0   -> finished. rdata is taken this cycle.
//   err has priority over hld.
//
// Ports:
//   hclk, hreset_n     clock, asynchronous active-low reset
//   haddr_i .. hsel_i  AHB-Lite address-phase and data-phase inputs
//   hready_i           bus-wide ready (previous transfer finished)
//   hrdata_o           read data, client word placed in its byte lane
//   hresp_o            1 = ERROR
//   hreadyout_o        0 = insert wait state
//   dv                 client request valid (first data-phase cycle)
//   hld                client stall
//   err                client error for the current request
//   write, addr        request direction and byte address
//   wdata              write data lane selected from hwdata_i
//   rdata              client read data
//   err_state          debug view of the error-response state machine
//                      (0 = OKAY, 1 = ERR1, 2 = ERR2)
// ----------------------------------------------------------------------------
module ahb_lite_slv_sif #(
    parameter int AHB_ADDR_WIDTH    = 32,
    parameter int AHB_DATA_WIDTH    = 64,
    parameter int CLIENT_DATA_WIDTH = 32
) (
    input  logic                         hclk,
    input  logic                         hreset_n,
    input  logic [AHB_ADDR_WIDTH-1:0]    haddr_i,
    input  logic [2:0]                   hsize_i,
    input  logic [1:0]                   htrans_i,
    input  logic [AHB_DATA_WIDTH-1:0]    hwdata_i,
    input  logic                         hwrite_i,
    input  logic                         hsel_i,
    input  logic                         hready_i,
    output logic [AHB_DATA_WIDTH-1:0]    hrdata_o,
    output logic                         hresp_o,
    output logic                         hreadyout_o,
    output logic                         dv,
    input  logic                         hld,
    input  logic                         err,
    output logic                         write,
    output logic [CLIENT_DATA_WIDTH-1:0] wdata,
    output logic [AHB_ADDR_WIDTH-1:0]    addr,
    input  logic [CLIENT_DATA_WIDTH-1:0] rdata,
    output logic [1:0]                   err_state
);

    localparam int LANES     = AHB_DATA_WIDTH / CLIENT_DATA_WIDTH;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int LANE_LSB  = $clog2(CLIENT_DATA_WIDTH / 8);
    localparam int IDX_W     = (LANE_BITS > 0) ? LANE_BITS : 1;

    // Widest hsize the client data path can carry.
    localparam logic [2:0] SIZE_MAX = 3'(LANE_LSB);

    localparam logic [1:0] ST_OKAY = 2'd0;
    localparam logic [1:0] ST_ERR1 = 2'd1;
    localparam logic [1:0] ST_ERR2 = 2'd2;

    logic                      pending_q;   // a data phase is in progress
    logic                      first_q;     // first cycle of that data phase
    logic [1:0]                state_q;
    logic [AHB_ADDR_WIDTH-1:0] addr_q;
    logic                      write_q;
    logic [2:0]                size_q;

    logic                      accept;
    logic                      size_viol;
    logic                      err_now;
    logic                      done_ok;
    logic [IDX_W-1:0]          lane_idx;

    // Only bit 1 of htrans matters: NONSEQ and SEQ are handled the same way.
    logic unused_htrans;
    assign unused_htrans = htrans_i[0];

    assign size_viol = (size_q > SIZE_MAX);

    // ERR1 is the data-phase cycle in which the error is seen. Its response
    // is driven combinationally from err / size_viol, so the registered state
    // only has to remember ERR2.
    assign err_now = pending_q & (err | size_viol);
    assign done_ok = pending_q & ~err_now & ~hld;

    assign hreadyout_o = (state_q == ST_ERR2) | ~pending_q | done_ok;
    assign hresp_o     = (state_q == ST_ERR2) | err_now;

    // Qualify with hreadyout_o as well, so that no new address phase is
    // taken while this subordinate is still holding its own data phase.
    assign accept = hsel_i & hready_i & htrans_i[1] & hreadyout_o;

    assign dv    = pending_q & first_q & ~size_viol;
    assign addr  = addr_q;
    assign write = write_q;

    assign err_state = (state_q == ST_ERR2) ? ST_ERR2 :
                       err_now              ? ST_ERR1 : ST_OKAY;

    generate
        if (LANE_BITS > 0) begin : g_lane
            assign lane_idx = addr_q[LANE_LSB +: LANE_BITS];
        end else begin : g_single
            assign lane_idx = '0;
        end
    endgenerate

    // Lane steering. Both outputs read zero outside a data phase, so that
    // they show their reset values when the block is idle.
    always_comb begin
        wdata    = '0;
        hrdata_o = '0;
        if (pending_q) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_idx == IDX_W'(i)) begin
                    wdata = hwdata_i[i*CLIENT_DATA_WIDTH +: CLIENT_DATA_WIDTH];
                    if (!write_q) begin
                        hrdata_o[i*CLIENT_DATA_WIDTH +: CLIENT_DATA_WIDTH] = rdata;
                    end
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            pending_q <= 1'b0;
            first_q   <= 1'b0;
            state_q   <= ST_OKAY;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= '0;
        end else begin
            // OKAY -> ERR1 (combinational) -> ERR2 -> OKAY
            state_q <= err_now ? ST_ERR2 : ST_OKAY;
            first_q <= 1'b0;
            if (accept) begin
                pending_q <= 1'b1;
                first_q   <= 1'b1;
                addr_q    <= haddr_i;
                write_q   <= hwrite_i;
                size_q    <= hsize_i;
            end else if (err_now || done_ok) begin
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_slv_sif.sv
// ----------------------------------------------------------------------------
// tb_ahb_lite_slv_sif
//
// Bench for ahb_lite_slv_sif in its 32-bit address, 64-bit AHB and 32-bit
// client configuration. The AHB fabric is modelled as a single subordinate,
// so hready_i follows hreadyout_o. Expected per-cycle responses come from a
// small transfer-level model: each transfer gives a list of
// {dv, hreadyout, hresp} triples.
// ----------------------------------------------------------------------------
module tb_ahb_lite_slv_sif;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int CW = 32;

    // ---------------- clock / reset ----------------
    logic          hclk = 1'b0;
    logic          hreset_n = 1'b0;
    always #5 hclk = ~hclk;

    logic [AW-1:0] haddr_i = '0;
    logic [2:0]    hsize_i = '0;
    logic [1:0]    htrans_i = '0;
    logic [DW-1:0] hwdata_i = '0;
    logic          hwrite_i = 1'b0;
    logic          hsel_i = 1'b0;
    logic          hready_i;
    logic [DW-1:0] hrdata_o;
    logic          hresp_o;
    logic          hreadyout_o;
    logic          dv;
    logic          hld = 1'b0;
    logic          err = 1'b0;
    logic          write;
    logic [CW-1:0] wdata;
    logic [AW-1:0] addr;
    logic [CW-1:0] rdata = '0;
    logic [1:0]    err_state;

    // The only subordinate on the bus, so the bus ready is its own ready.
    assign hready_i = hreadyout_o;

    ahb_lite_slv_sif #(
        .AHB_ADDR_WIDTH   (AW),
        .AHB_DATA_WIDTH   (DW),
        .CLIENT_DATA_WIDTH(CW)
    ) dut (
        .hclk       (hclk),
        .hreset_n   (hreset_n),
        .haddr_i    (haddr_i),
        .hsize_i    (hsize_i),
        .htrans_i   (htrans_i),
        .hwdata_i   (hwdata_i),
        .hwrite_i   (hwrite_i),
        .hsel_i     (hsel_i),
        .hready_i   (hready_i),
        .hrdata_o   (hrdata_o),
        .hresp_o    (hresp_o),
        .hreadyout_o(hreadyout_o),
        .dv         (dv),
        .hld        (hld),
        .err        (err),
        .write      (write),
        .wdata      (wdata),
        .addr       (addr),
        .rdata      (rdata),
        .err_state  (err_state)
    );

    // ---------------- scoreboard state ----------------
    logic [2:0]    exp_q[$];   // expected {dv, hreadyout, hresp} per data-phase cycle
    logic [2:0]    obs_q[$];
    logic [AW-1:0] obs_addr;
    logic          obs_write;
    logic [CW-1:0] obs_wdata;
    logic [DW-1:0] obs_hrdata;
    logic          obs_done_ok;
    int            n_total = 0;
    int            n_bad = 0;

    // ---------------- reference model ----------------
    // Builds the expected response sequence of one transfer: hold for n_hld
    // cycles, client error in cycle err_cyc (-1 = never), oversize if the
    // transfer is wider than 4 bytes.
    task automatic model_xfer(input logic [2:0] sz, input int n_hld, input int err_cyc);
        bit viol;
        bit dvk;
        exp_q.delete();
        viol = (sz > 3'd2);
        for (int k = 0; k < 16; k++) begin
            dvk = (k == 0) && !viol;
            if (viol || k == err_cyc) begin
                exp_q.push_back({dvk, 1'b0, 1'b1});
                exp_q.push_back({1'b0, 1'b1, 1'b1});
                break;
            end else if (k < n_hld) begin
                exp_q.push_back({dvk, 1'b0, 1'b0});
            end else begin
                exp_q.push_back({dvk, 1'b1, 1'b0});
                break;
            end
        end
    endtask

    function automatic logic [CW-1:0] exp_lane_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int lane;
        lane = int'((a >> 2) & 32'd1);
        return CW'(d >> (CW * lane));
    endfunction

    function automatic logic [DW-1:0] exp_lane_r(input logic [AW-1:0] a, input logic [CW-1:0] d);
        int lane;
        lane = int'((a >> 2) & 32'd1);
        return DW'(d) << (CW * lane);
    endfunction

    // ---------------- driver ----------------
    // Issues one address phase, then runs its data phase, recording what the
    // DUT returns each cycle until hreadyout_o goes high (at most 20 cycles).
    task automatic do_xfer(input logic [AW-1:0] a, input logic [2:0] sz, input logic wr,
                           input logic [DW-1:0] wd, input logic [CW-1:0] rd,
                           input int n_hld, input int err_cyc, input logic [1:0] tr);
        obs_q.delete();
        obs_done_ok = 1'b0;
        obs_hrdata  = '0;
        hsel_i   = 1'b1;
        htrans_i = tr;
        haddr_i  = a;
        hwrite_i = wr;
        hsize_i  = sz;
        @(posedge hclk); #1;
        hsel_i   = 1'b0;
        htrans_i = 2'b00;
        hwdata_i = wd;
        rdata    = rd;
        for (int k = 0; k < 20; k++) begin
            hld = (k < n_hld);
            err = (k == err_cyc);
            @(negedge hclk);
            obs_q.push_back({dv, hreadyout_o, hresp_o});
            if (k == 0) begin
                obs_addr  = addr;
                obs_write = write;
                obs_wdata = wdata;
            end
            if (hreadyout_o && !hresp_o) begin
                obs_done_ok = 1'b1;
                obs_hrdata  = hrdata_o;
            end
            if (hreadyout_o) break;
            @(posedge hclk); #1;
        end
        @(posedge hclk); #1;
        hld = 1'b0;
        err = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        hreset_n = 1'b0;
        rdata    = 32'hDEAD_BEEF;
        hwdata_i = {$urandom, $urandom} | 64'h1;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        n_total += 7;
        if (hreadyout_o !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout got=%b want=1", hreadyout_o); end
        if (hresp_o !== 1'b0)     begin n_bad++; $display("FAIL reset_hresp got=%b want=0", hresp_o); end
        if (hrdata_o !== '0)      begin n_bad++; $display("FAIL reset_hrdata got=%h want=0", hrdata_o); end
        if (dv !== 1'b0)          begin n_bad++; $display("FAIL reset_dv got=%b want=0", dv); end
        if (write !== 1'b0)       begin n_bad++; $display("FAIL reset_write got=%b want=0", write); end
        if (addr !== '0)          begin n_bad++; $display("FAIL reset_addr got=%h want=0", addr); end
        if (wdata !== '0)         begin n_bad++; $display("FAIL reset_wdata got=%h want=0", wdata); end
        @(posedge hclk); #1;
        hreset_n = 1'b1;
        hwdata_i = '0;
        rdata    = '0;
        @(posedge hclk); #1;
    endtask

    task automatic test_single_write();
        model_xfer(3'd2, 0, -1);
        do_xfer(32'h104, 3'd2, 1'b1, 64'hAABBCCDD_11223344, 32'h0, 0, -1, 2'b10);
        n_total++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL write_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL write_cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
        end
        n_total += 3;
        if (obs_addr !== 32'h104)       begin n_bad++; $display("FAIL write_addr got=%h want=00000104", obs_addr); end
        if (obs_write !== 1'b1)         begin n_bad++; $display("FAIL write_dir got=%b want=1", obs_write); end
        if (obs_wdata !== 32'hAABBCCDD) begin n_bad++; $display("FAIL write_wdata got=%h want=aabbccdd", obs_wdata); end
    endtask

    task automatic test_single_read();
        logic [AW-1:0] a;
        for (int j = 0; j < 2; j++) begin
            a = (j == 0) ? 32'h100 : 32'h104;
            model_xfer(3'd2, 0, -1);
            do_xfer(a, 3'd2, 1'b0, 64'h0, 32'h12345678, 0, -1, 2'b10);
            n_total++;
            if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL read_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                n_total++;
                if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL read_cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
            end
            n_total += 2;
            if (obs_write !== 1'b0) begin n_bad++; $display("FAIL read_dir got=%b want=0", obs_write); end
            if (obs_hrdata !== exp_lane_r(a, 32'h12345678)) begin
                n_bad++;
                $display("FAIL read_hrdata addr=%h got=%h want=%h", a, obs_hrdata, exp_lane_r(a, 32'h12345678));
            end
        end
    endtask

    task automatic test_stall();
        model_xfer(3'd2, 3, -1);
        do_xfer(32'h40, 3'd2, 1'b0, 64'h0, 32'hCAFE_F00D, 3, -1, 2'b10);
        n_total++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL stall_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL stall_cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
        end
        n_total++;
        if (obs_hrdata !== 64'h00000000_CAFEF00D) begin n_bad++; $display("FAIL stall_hrdata got=%h want=00000000cafef00d", obs_hrdata); end
    endtask

    task automatic test_client_error();
        // err in the dv cycle, then err during a stall (priority over hld)
        for (int j = 0; j < 2; j++) begin
            int nh;
            int ec;
            nh = (j == 0) ? 0 : 4;
            ec = (j == 0) ? 0 : 2;
            model_xfer(3'd2, nh, ec);
            do_xfer(32'h10, 3'd2, 1'b1, 64'h5, 32'h0, nh, ec, 2'b10);
            n_total++;
            if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL cerr%0d_len got=%0d want=%0d", j, obs_q.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                n_total++;
                if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL cerr%0d_cyc%0d got=%b want=%b", j, i, obs_q[i], exp_q[i]); end
            end
            // the cycle after ERR2 is back to OKAY
            @(negedge hclk);
            n_total++;
            if ({hreadyout_o, hresp_o} !== 2'b10) begin n_bad++; $display("FAIL cerr%0d_after got=%b want=10", j, {hreadyout_o, hresp_o}); end
            @(posedge hclk); #1;
        end
    endtask

    task automatic test_oversize();
        model_xfer(3'd3, 0, -1);
        do_xfer(32'h8, 3'd3, 1'b1, 64'h1234, 32'h0, 0, -1, 2'b10);
        n_total++;
        if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL oversize_len got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_total++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL oversize_cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        da = {$urandom, $urandom};
        db = {$urandom, $urandom};
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h0; hwrite_i = 1'b1; hsize_i = 3'd2;
        @(posedge hclk); #1;
        htrans_i = 2'b11; haddr_i = 32'h4; hwdata_i = da;
        @(negedge hclk);
        n_total += 4;
        if ({dv, hreadyout_o, hresp_o} !== 3'b110) begin n_bad++; $display("FAIL b2b_a_resp got=%b want=110", {dv, hreadyout_o, hresp_o}); end
        if (addr !== 32'h0)                        begin n_bad++; $display("FAIL b2b_a_addr got=%h want=0", addr); end
        if (write !== 1'b1)                        begin n_bad++; $display("FAIL b2b_a_write got=%b want=1", write); end
        if (wdata !== exp_lane_w(32'h0, da))       begin n_bad++; $display("FAIL b2b_a_wdata got=%h want=%h", wdata, exp_lane_w(32'h0, da)); end
        @(posedge hclk); #1;
        htrans_i = 2'b00; haddr_i = 32'h80; hwdata_i = db;   // selected IDLE
        @(negedge hclk);
        n_total += 3;
        if ({dv, hreadyout_o, hresp_o} !== 3'b110) begin n_bad++; $display("FAIL b2b_b_resp got=%b want=110", {dv, hreadyout_o, hresp_o}); end
        if (addr !== 32'h4)                        begin n_bad++; $display("FAIL b2b_b_addr got=%h want=4", addr); end
        if (wdata !== exp_lane_w(32'h4, db))       begin n_bad++; $display("FAIL b2b_b_wdata got=%h want=%h", wdata, exp_lane_w(32'h4, db)); end
        @(posedge hclk); #1;
        hsel_i = 1'b0;
        @(negedge hclk);
        n_total++;
        if ({dv, hreadyout_o, hresp_o} !== 3'b010) begin n_bad++; $display("FAIL idle_resp got=%b want=010", {dv, hreadyout_o, hresp_o}); end
        @(posedge hclk); #1;
    endtask

    task automatic test_reset_abort();
        hsel_i = 1'b1; htrans_i = 2'b10; haddr_i = 32'h208; hwrite_i = 1'b1; hsize_i = 3'd2;
        @(posedge hclk); #1;
        hsel_i = 1'b0; htrans_i = 2'b00; hld = 1'b1;
        @(negedge hclk);
        #2 hreset_n = 1'b0;
        #1;
        n_total += 4;
        if ({dv, hreadyout_o, hresp_o} !== 3'b010) begin n_bad++; $display("FAIL abort_resp got=%b want=010", {dv, hreadyout_o, hresp_o}); end
        if (addr !== '0)     begin n_bad++; $display("FAIL abort_addr got=%h want=0", addr); end
        if (write !== 1'b0)  begin n_bad++; $display("FAIL abort_write got=%b want=0", write); end
        if (wdata !== '0)    begin n_bad++; $display("FAIL abort_wdata got=%h want=0", wdata); end
        @(posedge hclk); #1;
        hreset_n = 1'b1;
        hld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge hclk);
            n_total++;
            if ({dv, hreadyout_o, hresp_o} !== 3'b010) begin n_bad++; $display("FAIL abort_post%0d got=%b want=010", k, {dv, hreadyout_o, hresp_o}); end
        end
        @(posedge hclk); #1;
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [2:0]    sz;
        logic          wr;
        logic [DW-1:0] wd;
        logic [CW-1:0] rd;
        logic [1:0]    tr;
        int            nh;
        int            ec;
        for (int t = 0; t < 40; t++) begin
            a  = $urandom;
            sz = 3'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            rd = $urandom;
            tr = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
            nh = int'($urandom_range(0, 3));
            ec = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nh)) : -1;
            model_xfer(sz, nh, ec);
            do_xfer(a, sz, wr, wd, rd, nh, ec, tr);
            n_total++;
            if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd%0d_len got=%0d want=%0d", t, obs_q.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                n_total++;
                if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd%0d_cyc%0d got=%b want=%b", t, i, obs_q[i], exp_q[i]); end
            end
            if (sz <= 3'd2) begin
                n_total += 3;
                if (obs_addr !== a)                 begin n_bad++; $display("FAIL rnd%0d_addr got=%h want=%h", t, obs_addr, a); end
                if (obs_write !== wr)               begin n_bad++; $display("FAIL rnd%0d_write got=%b want=%b", t, obs_write, wr); end
                if (obs_wdata !== exp_lane_w(a, wd)) begin n_bad++; $display("FAIL rnd%0d_wdata got=%h want=%h", t, obs_wdata, exp_lane_w(a, wd)); end
                if (!wr && ec < 0) begin
                    n_total++;
                    if (obs_hrdata !== exp_lane_r(a, rd)) begin n_bad++; $display("FAIL rnd%0d_hrdata got=%h want=%h", t, obs_hrdata, exp_lane_r(a, rd)); end
                end
            end
            repeat ($urandom_range(0, 2)) begin @(posedge hclk); #1; end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_stall();
        test_client_error();
        test_oversize();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
